// File: rtl/reader_pkg.sv
// reader_pkg: shared definitions for the switch operand reader.
//   state_t           - FSM states (IDLE, HOLD, WAIT_RELEASE)
//   DEBOUNCE_DEFAULT  - default debounce hold count (1 ms at 27 MHz)
//   DROP_W / DROP_MAX - width and saturation value of the dropped-press counter
package reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_RELEASE
    } state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 27000;
    localparam int unsigned DROP_W           = 4;
    localparam logic [DROP_W-1:0] DROP_MAX   = '1;

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchronizer followed by a consecutive-cycle debouncer.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset (clears sync flops, stable, counter)
//   raw    - asynchronous input
//   stable - debounced value; follows raw 2+DEBOUNCE_CYCLES cycles after a clean edge
module debounce_cell
    import reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any cycle where synced agrees with stable restarts the count,
            // so a bounce back to the old level discards progress.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_operand_reader.sv
// switch_operand_reader: captures two 2-bit operands from slide switches on a
// debounced load-button press and offers them with a valid/ready handshake.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   sw_raw  - async switches; [1:0] = v1, [3:2] = v2
//   btn_raw - async active-high load button
//   ready   - consumer accepts the pair (transfer when valid & ready)
//   v1, v2  - captured operands
//   valid   - an unconsumed pair is held
//   dropped - saturating count of presses ignored while not IDLE
// Build option: READER_AUTO_LOAD_EN - a change of the stable switch vector in
// IDLE also triggers a capture.
module switch_operand_reader
    import reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        sw_raw,
    input  logic              btn_raw,
    input  logic              ready,
    output logic [1:0]        v1,
    output logic [1:0]        v2,
    output logic              valid,
    output logic [DROP_W-1:0] dropped
);

    logic [4:0] raw_bus;
    logic [4:0] stable_bus;
    logic [3:0] sw_stable;
    logic       btn_stable;
    logic       btn_prev;
    logic       btn_rise;
    logic       load_req;
    logic       capture;
    logic       drop;
    state_t     state;
    state_t     state_next;

    assign raw_bus = {btn_raw, sw_raw};

    for (genvar i = 0; i < 5; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_bus[i]),
            .stable(stable_bus[i])
        );
    end

    assign sw_stable  = stable_bus[3:0];
    assign btn_stable = stable_bus[4];
    assign btn_rise   = btn_stable & ~btn_prev;

`ifdef READER_AUTO_LOAD_EN
    logic [3:0] sw_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_prev <= '0;
        end else begin
            sw_prev <= sw_stable;
        end
    end

    assign load_req = btn_rise | (sw_stable != sw_prev);
`else
    assign load_req = btn_rise;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:         if (load_req)    state_next = HOLD;
            HOLD:         if (ready)       state_next = WAIT_RELEASE;
            WAIT_RELEASE: if (!btn_stable) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        valid   = (state == HOLD);
        capture = (state == IDLE) && load_req;
        // Only button edges count as dropped; switch-triggered loads never do.
        drop    = (state != IDLE) && btn_rise;
    end

    // Datapath: operand capture samples the switch value registered before
    // this edge, so a switch settling on the capture edge is not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 1'b0;
            v1       <= '0;
            v2       <= '0;
            dropped  <= '0;
        end else begin
            btn_prev <= btn_stable;
            if (capture) begin
                v1 <= sw_stable[1:0];
                v2 <= sw_stable[3:2];
            end
            if (drop && (dropped != DROP_MAX)) begin
                dropped <= dropped + DROP_W'(1);
            end
        end
    end

endmodule

// File: doc/switch_operand_reader.md
SWITCH_OPERAND_READER -- requirements
Module: switch_operand_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 27000, SHALL set the consecutive-cycle count a synchronized input must hold before it is accepted (1 ms at 27 MHz).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset; one clock, reset synchronous and active-high.
REQ-004 sw_raw  input  4  SHALL carry asynchronous slide switches; bits [1:0] = operand v1, bits [3:2] = operand v2.
REQ-005 btn_raw  input  1  SHALL carry the asynchronous, active-high, bouncing load push-button.
REQ-006 v1  output  2  SHALL present the captured first operand for the adder/LED display path.
REQ-007 v2  output  2  SHALL present the captured second operand.
REQ-008 valid  output  1  SHALL flag that v1/v2 hold an unconsumed operand pair.
REQ-009 ready  input  1  SHALL indicate the consumer accepts the pair; transfer occurs on a cycle with valid=1 and ready=1.
REQ-010 dropped  output  4  SHALL count load presses ignored while not idle, saturating at 15.

Function
REQ-011 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized input SHALL have its own debounce counter: cleared whenever synced equals stable; incremented while they differ; when it reaches DEBOUNCE_CYCLES-1 with synced still different, stable takes synced and the counter clears.
REQ-013 Raw-to-stable latency SHALL be exactly 2+DEBOUNCE_CYCLES cycles for a clean edge; any bounce restarts the count.
REQ-014 FSM SHALL have states IDLE, HOLD, WAIT_RELEASE.
REQ-015 IDLE -> HOLD on the cycle the stable button shows a 0->1 edge; on that edge v1/v2 SHALL load from the stable switch values and valid SHALL be 1 from the next cycle.
REQ-016 In HOLD, valid SHALL stay 1 and v1/v2 SHALL stay constant regardless of switch changes until valid&ready.
REQ-017 HOLD -> WAIT_RELEASE on valid&ready; valid SHALL be 0 from the following cycle; v1/v2 SHALL retain their last values.
REQ-018 WAIT_RELEASE -> IDLE on the first cycle the stable button is 0; if already 0 at entry, the transition SHALL occur on the next cycle.
REQ-019 A stable button 0->1 edge in HOLD or WAIT_RELEASE SHALL NOT capture and SHALL increment dropped (saturate at 15, no wrap).
REQ-020 ready while valid=0 SHALL have no effect.
REQ-021 Switch change and button edge stabilizing in the same cycle: capture SHALL use the switch stable value before that edge updates.

Reset
REQ-022 While rst=1: v1=0, v2=0, valid=0, dropped=0, FSM=IDLE, all synchronizer flops, stable values and debounce counters 0.
REQ-023 rst asserted mid-operation (including HOLD with valid=1) SHALL abandon the pending pair; no transfer is signalled afterwards.
REQ-024 After rst deasserts, a held button SHALL be seen as a fresh 0->1 edge after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-025 Macro READER_AUTO_LOAD_EN defined: in IDLE, any change of the stable switch vector SHALL also trigger a capture identical to a button edge, capturing the new switch value; undefined: only the button triggers capture and switch changes alone never assert valid.
REQ-026 With READER_AUTO_LOAD_EN defined, switch changes outside IDLE SHALL NOT increment dropped.

Structure
REQ-027 Shared package reader_pkg SHALL hold the FSM state typedef (IDLE, HOLD, WAIT_RELEASE), the DEBOUNCE_CYCLES default and the dropped-counter width constant.
REQ-028 Synchronizer plus debounce counter SHALL be one sub-module, debounce_cell, instantiated 5 times.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 sw_raw=4'b1001, clean btn press held, ready=0 -> valid=1 at 7 cycles after btn edge, v1=2'b01, v2=2'b10, held unchanged while sw_raw toggles.
REQ-030 btn bounces 1,0,1,0 each cycle, then stays 1 -> no capture until 6 cycles after the last bounce edge; exactly one valid.
REQ-031 valid=1, ready pulsed 1 cycle -> valid=0 next cycle; second press without release -> dropped=1; release, press again -> new capture.
REQ-032 20 presses while HOLD with ready=0 -> dropped=15, not 4.
REQ-033 rst asserted during HOLD -> next cycle valid=0, v1=v2=0, dropped=0; held button recaptures 6 cycles after rst falls.
REQ-034 READER_AUTO_LOAD_EN defined, IDLE, sw_raw 0000->0110, no button -> valid=1 with v1=2'b10, v2=2'b01; undefined -> valid stays 0.
